// File: rtl/ik_sched_pkg.sv
// Shared types and constants for the inverse-kinematics job scheduler.
// Q16.15 constants are provided for benches that model the core.
package ik_sched_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    HOLD = 2'd2,
    RESP = 2'd3
  } ik_state_t;

  localparam int IK_BIT_WIDTH     = 32;
  localparam int IK_FRACTIONS     = 15;
  localparam int IK_SETTLE_CYCLES = 64;

  // 11.0 and 12.0 in Q16.15
  localparam logic [IK_BIT_WIDTH-1:0] IK_CONST_11 = 32'h0005_8000;
  localparam logic [IK_BIT_WIDTH-1:0] IK_CONST_12 = 32'h0006_0000;

endpackage

// File: rtl/ik_rr_arbiter.sv
// Request arbiter: combinational one-hot grant plus binary index.
// IK_SCHED_RR_EN selects round-robin (owns the pointer); otherwise fixed priority, lowest index wins.
module ik_rr_arbiter
  import ik_sched_pkg::*;
#(
  parameter int N_REQ = 4,
  parameter int ID_W  = $clog2(N_REQ)
) (
  input  logic             clock,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  input  logic             grant_take,
  output logic [N_REQ-1:0] grant,
  output logic [ID_W-1:0]  grant_idx
);

`ifdef IK_SCHED_RR_EN
  logic [ID_W-1:0] ptr;

  // Search upward from the pointer; walking downward lets the nearest hit win.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[(int'(ptr) + i) % N_REQ]) begin
        grant                                = '0;
        grant[(int'(ptr) + i) % N_REQ]       = 1'b1;
        grant_idx = ID_W'((int'(ptr) + i) % N_REQ);
      end else begin
        grant = grant;
      end
    end
  end

  // Pointer moves just past the winner on every accepted grant.
  always_ff @(posedge clock) begin
    if (rst) begin
      ptr <= '0;
    end else if (grant_take) begin
      ptr <= (grant_idx == ID_W'(N_REQ - 1)) ? '0 : grant_idx + ID_W'(1);
    end else begin
      ptr <= ptr;
    end
  end
`else
  logic unused_ports;
  assign unused_ports = ^{clock, rst, grant_take};

  // Fixed priority: the lowest valid index is written last and wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--) begin
      if (req[i]) begin
        grant     = '0;
        grant[i]  = 1'b1;
        grant_idx = ID_W'(i);
      end else begin
        grant = grant;
      end
    end
  end
`endif

endmodule

// File: rtl/ik_job_scheduler.sv
// Shares one inverse-kinematics core between N_REQ requesters: grant, hold inputs, settle, respond.
// Arbitration is round-robin when IK_SCHED_RR_EN is defined, fixed priority otherwise.
module ik_job_scheduler
  import ik_sched_pkg::*;
#(
  parameter int N_REQ         = 4,
  parameter int BIT_WIDTH     = IK_BIT_WIDTH,
  parameter int SETTLE_CYCLES = IK_SETTLE_CYCLES,
  parameter int ID_W          = $clog2(N_REQ)
) (
  input  logic                       clock,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_ready,
  input  logic [N_REQ*BIT_WIDTH-1:0] req_x,
  input  logic [N_REQ*BIT_WIDTH-1:0] req_y,
  output logic                       rsp_valid,
  input  logic                       rsp_ready,
  output logic [ID_W-1:0]            rsp_id,
  output logic [BIT_WIDTH-1:0]       rsp_theta1,
  output logic [BIT_WIDTH-1:0]       rsp_theta2,
  output logic [BIT_WIDTH-1:0]       core_x,
  output logic [BIT_WIDTH-1:0]       core_y,
  output logic                       core_rst,
  input  logic [BIT_WIDTH-1:0]       core_theta1,
  input  logic [BIT_WIDTH-1:0]       core_theta2,
  output logic                       busy
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

  ik_state_t        state;
  ik_state_t        next_state;
  logic [CNT_W-1:0] cnt;
  logic             grant_take;
  logic [N_REQ-1:0] grant;
  logic [ID_W-1:0]  grant_idx;

  ik_rr_arbiter #(
    .N_REQ (N_REQ),
    .ID_W  (ID_W)
  ) u_arb (
    .clock      (clock),
    .rst        (rst),
    .req        (req_valid),
    .grant_take (grant_take),
    .grant      (grant),
    .grant_idx  (grant_idx)
  );

  // State register.
  always_ff @(posedge clock) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next state and the combinational accept strobe, which exists only in IDLE.
  always_comb begin
    next_state = state;
    grant_take = 1'b0;
    req_ready  = '0;
    case (state)
      IDLE: begin
        if (!rst && (|req_valid)) begin
          grant_take = 1'b1;
          req_ready  = grant;
          next_state = LOAD;
        end else begin
          next_state = IDLE;
        end
      end
      LOAD: next_state = HOLD;
      HOLD: begin
        if (cnt == '0) begin
          next_state = RESP;
        end else begin
          next_state = HOLD;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          next_state = IDLE;
        end else begin
          next_state = RESP;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // Job data, settle counter and result capture; core inputs persist between jobs.
  always_ff @(posedge clock) begin
    if (rst) begin
      core_x     <= '0;
      core_y     <= '0;
      rsp_id     <= '0;
      rsp_theta1 <= '0;
      rsp_theta2 <= '0;
      cnt        <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (grant_take) begin
            core_x <= req_x[grant_idx*BIT_WIDTH +: BIT_WIDTH];
            core_y <= req_y[grant_idx*BIT_WIDTH +: BIT_WIDTH];
            rsp_id <= grant_idx;
          end
        end
        LOAD: cnt <= CNT_W'(SETTLE_CYCLES - 1);
        HOLD: begin
          if (cnt == '0) begin
            rsp_theta1 <= core_theta1;
            rsp_theta2 <= core_theta2;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        default: cnt <= cnt;
      endcase
    end
  end

  assign rsp_valid = (state == RESP);
  assign busy      = (state != IDLE);
  assign core_rst  = rst | (state == LOAD);

endmodule

// File: tb/tb_ik_job_scheduler.sv
// Self-checking bench for ik_job_scheduler with a stub core (theta1=x+y, theta2=x-y).
// Expectations adapt to the IK_SCHED_RR_EN build.
module tb_ik_job_scheduler;
  import ik_sched_pkg::*;

  localparam int N   = 4;
  localparam int BW  = IK_BIT_WIDTH;
  localparam int IDW = 2;

  typedef struct packed {
    logic [IDW-1:0] id;
    logic [BW-1:0]  t1;
    logic [BW-1:0]  t2;
  } exp_t;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic            rst = 1'b1;
  logic [N-1:0]    req_valid = '0;
  logic [N-1:0]    req_ready;
  logic [N*BW-1:0] req_x = '0;
  logic [N*BW-1:0] req_y = '0;
  logic            rsp_valid;
  logic            rsp_ready = 1'b1;
  logic [IDW-1:0]  rsp_id;
  logic [BW-1:0]   rsp_theta1, rsp_theta2, core_x, core_y, core_theta1, core_theta2;
  logic            core_rst, busy;

  logic [N-1:0]    b_req_valid = '0;
  logic [N-1:0]    b_req_ready;
  logic [N*BW-1:0] b_req_x = '0;
  logic [N*BW-1:0] b_req_y = '0;
  logic            b_rsp_valid;
  logic            b_rsp_ready = 1'b1;
  logic [IDW-1:0]  b_rsp_id;
  logic [BW-1:0]   b_rsp_theta1, b_rsp_theta2, b_core_x, b_core_y, b_core_theta1, b_core_theta2;
  logic            b_core_rst, b_busy;

  assign core_theta1   = core_x + core_y;
  assign core_theta2   = core_x - core_y;
  assign b_core_theta1 = b_core_x + b_core_y;
  assign b_core_theta2 = b_core_x - b_core_y;

  ik_job_scheduler #(.N_REQ(N), .BIT_WIDTH(BW), .SETTLE_CYCLES(4), .ID_W(IDW)) dut (
    .clock(clock), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_x(req_x), .req_y(req_y), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_id(rsp_id), .rsp_theta1(rsp_theta1), .rsp_theta2(rsp_theta2),
    .core_x(core_x), .core_y(core_y), .core_rst(core_rst),
    .core_theta1(core_theta1), .core_theta2(core_theta2), .busy(busy)
  );

  ik_job_scheduler #(.N_REQ(N), .BIT_WIDTH(BW), .SETTLE_CYCLES(1), .ID_W(IDW)) dut_s1 (
    .clock(clock), .rst(rst), .req_valid(b_req_valid), .req_ready(b_req_ready),
    .req_x(b_req_x), .req_y(b_req_y), .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready),
    .rsp_id(b_rsp_id), .rsp_theta1(b_rsp_theta1), .rsp_theta2(b_rsp_theta2),
    .core_x(b_core_x), .core_y(b_core_y), .core_rst(b_core_rst),
    .core_theta1(b_core_theta1), .core_theta2(b_core_theta2), .busy(b_busy)
  );

  exp_t sb[$];
  int   checks = 0;
  int   failures = 0;
  logic leak_seen = 1'b0;

  task automatic set_xy(input int i, input logic [BW-1:0] x, input logic [BW-1:0] y);
    req_x[i*BW +: BW] = x;
    req_y[i*BW +: BW] = y;
  endtask

  task automatic push_exp(input int i);
    logic [BW-1:0] x;
    logic [BW-1:0] y;
    x = req_x[i*BW +: BW];
    y = req_y[i*BW +: BW];
    sb.push_back({IDW'(i), x + y, x - y});
  endtask

  task automatic do_reset;
    @(negedge clock);
    rst = 1'b1;
    req_valid = '0;
    b_req_valid = '0;
    rsp_ready = 1'b1;
    b_rsp_ready = 1'b1;
    sb.delete();
    repeat (2) @(negedge clock);
    rst = 1'b0;
  endtask

  // Bounded wait for rsp_valid on the main instance; notes any grant leaking while busy.
  task automatic wait_rsp(input int limit, output int n);
    n = -1;
    for (int c = 1; c <= limit; c++) begin
      @(negedge clock);
      if (busy && (req_ready !== '0)) leak_seen = 1'b1;
      if (rsp_valid) begin
        n = c;
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clock);
    #1;
    checks++;
    if ({req_ready, rsp_valid, busy, core_rst} !== 7'b0000_0_0_1) begin
      failures++;
      $display("FAIL reset_ctrl got=%b want=%b", {req_ready, rsp_valid, busy, core_rst}, 7'b0000001);
    end
    checks++;
    if ({rsp_id, rsp_theta1, rsp_theta2, core_x, core_y} !== '0) begin
      failures++;
      $display("FAIL reset_data got id=%0d t1=%h t2=%h x=%h y=%h want all zero",
               rsp_id, rsp_theta1, rsp_theta2, core_x, core_y);
    end
    checks++;
    if ({b_req_ready, b_rsp_valid, b_busy, b_core_rst} !== 7'b0000_0_0_1) begin
      failures++;
      $display("FAIL reset_s1 got=%b want=%b", {b_req_ready, b_rsp_valid, b_busy, b_core_rst}, 7'b0000001);
    end
    rst = 1'b0;
    #1;
    checks++;
    if (core_rst !== 1'b0) begin
      failures++;
      $display("FAIL reset_release core_rst got=%b want=0", core_rst);
    end
  endtask

  task automatic test_single;
    int   n;
    int   rst_cycles;
    logic ready_bad;
    exp_t e;
    do_reset;
    set_xy(2, 32'h0008_0000, 32'h0001_8000);
    req_valid = 4'b0100;
    #1;
    checks++;
    if (req_ready !== 4'b0100) begin
      failures++;
      $display("FAIL single_ready got=%b want=0100", req_ready);
    end
    push_exp(2);
    n = -1;
    rst_cycles = 0;
    ready_bad = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      @(negedge clock);
      req_valid = '0;
      #1;
      if (core_rst) rst_cycles++;
      if (req_ready !== '0) ready_bad = 1'b1;
      if (rsp_valid) begin
        n = c;
        break;
      end
    end
    checks++;
    if (n != 6) begin
      failures++;
      $display("FAIL single_latency got=%0d want=6", n);
    end
    checks++;
    if (rst_cycles != 1 || ready_bad) begin
      failures++;
      $display("FAIL single_core_rst got=%0d cycles ready_bad=%b want 1 cycle, 0", rst_cycles, ready_bad);
    end
    e = sb.pop_front();
    checks++;
    if ({rsp_id, rsp_theta1, rsp_theta2} !== {2'd2, 32'h0009_8000, 32'h0006_8000} ||
        {rsp_id, rsp_theta1, rsp_theta2} !== e) begin
      failures++;
      $display("FAIL single_rsp got=%h want=%h", {rsp_id, rsp_theta1, rsp_theta2}, e);
    end
    @(negedge clock);
    checks++;
    if ({busy, rsp_valid, core_x, core_y} !== {1'b0, 1'b0, 32'h0008_0000, 32'h0001_8000}) begin
      failures++;
      $display("FAIL single_after got busy=%b valid=%b x=%h y=%h want 0 0 00080000 00018000",
               busy, rsp_valid, core_x, core_y);
    end
  endtask

  task automatic test_contention;
    int           n;
    int           g;
    logic         got;
    logic [N-1:0] oh;
    exp_t         e;
    do_reset;
    for (int i = 0; i < N; i++) set_xy(i, BW'(65536 * (i + 1)), BW'(1024 * (i + 3)));
`ifdef IK_SCHED_RR_EN
    req_valid = 4'b1111;
`else
    req_valid = 4'b1010;
`endif
    #1;
    leak_seen = 1'b0;
    for (int k = 0; k < 5; k++) begin
`ifdef IK_SCHED_RR_EN
      g = k % N;
`else
      g = 1;
`endif
      got = 1'b0;
      for (int c = 0; c < 30; c++) begin
        if (busy && (req_ready !== '0)) leak_seen = 1'b1;
        if (!busy && (req_ready !== '0)) begin
          got = 1'b1;
          break;
        end
        @(negedge clock);
        #1;
      end
      oh = '0;
      oh[g] = 1'b1;
      checks++;
      if (!got || req_ready !== oh) begin
        failures++;
        $display("FAIL contention_grant k=%0d got=%b want=%b", k, req_ready, oh);
      end
      push_exp(g);
      wait_rsp(30, n);
      e = sb.pop_front();
      checks++;
      if (n < 0 || {rsp_id, rsp_theta1, rsp_theta2} !== e) begin
        failures++;
        $display("FAIL contention_rsp k=%0d got=%h want=%h", k, {rsp_id, rsp_theta1, rsp_theta2}, e);
      end
      if (k == 4) req_valid = '0;
    end
    checks++;
    if (leak_seen) begin
      failures++;
      $display("FAIL contention_leak got=1 want=0 (req_ready while busy)");
    end
    @(negedge clock);
  endtask

  task automatic test_backpressure;
    int   n;
    logic bad;
    exp_t e;
    do_reset;
    set_xy(0, 32'h0002_0000, 32'h0000_8000);
    set_xy(1, 32'h0003_0000, 32'h0001_0000);
    rsp_ready = 1'b0;
    req_valid = 4'b0011;
    #1;
    checks++;
    if (req_ready !== 4'b0001) begin
      failures++;
      $display("FAIL bp_grant got=%b want=0001", req_ready);
    end
    push_exp(0);
    @(negedge clock);
    req_valid = 4'b0010;
    wait_rsp(30, n);
    e = sb.pop_front();
    bad = (n < 0);
    for (int c = 0; c <= 10; c++) begin
      if ({rsp_valid, busy, req_ready} !== 6'b11_0000 || {rsp_id, rsp_theta1, rsp_theta2} !== e) bad = 1'b1;
      if (c < 10) @(negedge clock);
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL bp_hold got=%h v=%b busy=%b rdy=%b want=%h v=1 busy=1 rdy=0",
               {rsp_id, rsp_theta1, rsp_theta2}, rsp_valid, busy, req_ready, e);
    end
    rsp_ready = 1'b1;
    @(negedge clock);
    #1;
    checks++;
    if ({busy, rsp_valid, req_ready} !== 6'b00_0010) begin
      failures++;
      $display("FAIL bp_release got busy=%b v=%b rdy=%b want 0 0 0010", busy, rsp_valid, req_ready);
    end
    req_valid = '0;
    @(negedge clock);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL bp_drop got busy=%b want=0", busy);
    end
  endtask

  task automatic test_reset_mid;
    int   n;
    logic bad;
    exp_t e;
    do_reset;
    set_xy(1, 32'h0004_0000, 32'h0002_0000);
    set_xy(3, 32'h0007_0000, 32'h0000_1000);
    req_valid = 4'b0010;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      failures++;
      $display("FAIL mid_grant got=%b want=0010", req_ready);
    end
    @(negedge clock);
    req_valid = '0;
    repeat (2) @(negedge clock);
    checks++;
    if ({busy, rsp_valid, core_x} !== {1'b1, 1'b0, 32'h0004_0000}) begin
      failures++;
      $display("FAIL mid_hold got busy=%b v=%b x=%h want 1 0 00040000", busy, rsp_valid, core_x);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (core_rst !== 1'b1) begin
      failures++;
      $display("FAIL mid_core_rst got=%b want=1", core_rst);
    end
    @(negedge clock);
    rst = 1'b0;
    #1;
    checks++;
    if ({req_ready, rsp_valid, busy, core_rst, rsp_id, rsp_theta1, rsp_theta2, core_x, core_y} !== '0) begin
      failures++;
      $display("FAIL mid_state got rdy=%b v=%b busy=%b crst=%b id=%0d x=%h y=%h want all zero",
               req_ready, rsp_valid, busy, core_rst, rsp_id, core_x, core_y);
    end
    bad = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(negedge clock);
      if (rsp_valid !== 1'b0 || busy !== 1'b0) bad = 1'b1;
    end
    checks++;
    if (bad) begin
      failures++;
      $display("FAIL mid_no_rsp got activity after abort want none");
    end
    req_valid = 4'b1010;
    #1;
    checks++;
    if (req_ready !== 4'b0010) begin
      failures++;
      $display("FAIL mid_ptr got=%b want=0010", req_ready);
    end
    push_exp(1);
    @(negedge clock);
    req_valid = '0;
    wait_rsp(30, n);
    e = sb.pop_front();
    checks++;
    if (n < 0 || {rsp_id, rsp_theta1, rsp_theta2} !== e) begin
      failures++;
      $display("FAIL mid_rsp got=%h want=%h", {rsp_id, rsp_theta1, rsp_theta2}, e);
    end
    @(negedge clock);
  endtask

  task automatic test_boundary;
    int   n;
    logic hold_ok;
    do_reset;
    b_req_x[2*BW +: BW] = 32'h0001_2345;
    b_req_y[2*BW +: BW] = 32'h0000_1111;
    b_req_valid = 4'b0100;
    #1;
    checks++;
    if (b_req_ready !== 4'b0100) begin
      failures++;
      $display("FAIL bound_grant got=%b want=0100", b_req_ready);
    end
    n = -1;
    hold_ok = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      @(negedge clock);
      b_req_valid = '0;
      #1;
      if (c == 2) hold_ok = ({b_busy, b_core_rst, b_core_x, b_core_y} === {1'b1, 1'b0, 32'h0001_2345, 32'h0000_1111});
      if (b_rsp_valid) begin
        n = c;
        break;
      end
    end
    checks++;
    if (n != 3 || !hold_ok) begin
      failures++;
      $display("FAIL bound_latency got=%0d hold_ok=%b want=3 1", n, hold_ok);
    end
    checks++;
    if ({b_rsp_id, b_rsp_theta1, b_rsp_theta2} !== {2'd2, 32'h0001_3456, 32'h0001_1234}) begin
      failures++;
      $display("FAIL bound_rsp got=%h want=%h", {b_rsp_id, b_rsp_theta1, b_rsp_theta2},
               {2'd2, 32'h0001_3456, 32'h0001_1234});
    end
    @(negedge clock);
  endtask

  initial begin
    test_reset;
    test_single;
    test_contention;
    test_backpressure;
    test_reset_mid;
    test_boundary;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
